// File: rtl/predictor_pkg.sv
// predictor_pkg
// Shared definitions for the perceptron branch-predictor controller:
// fixed-point widths, symbol encodings, the default learn margin and the
// sequencer state encoding.
package predictor_pkg;

    // Q4.5 signed fixed point used for y, abs_w and GAMMA
    localparam int Q_W    = 10;
    localparam int Q_FRAC = 5;
    localparam int PROD_W = 2 * Q_W;

    // Accuracy ratio width shown on the LEDs
    localparam int LED_W = 8;

    // Input symbols as 2-bit signed values
    localparam logic [1:0] SYM_POS = 2'b01;
    localparam logic [1:0] SYM_NEG = 2'b11;

    // Default learn margin, 45/32 in Q4.5
    localparam logic signed [Q_W-1:0] GAMMA_DEFAULT = 10'sd45;

    // Sequencer state encodings
    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_COMPARE    = 3'd1;
    localparam logic [2:0] ST_LEARN      = 3'd2;
    localparam logic [2:0] ST_LEARN_CLR  = 3'd3;
    localparam logic [2:0] ST_UPDATE     = 3'd4;
    localparam logic [2:0] ST_UPDATE_CLR = 3'd5;
    localparam logic [2:0] ST_DIV        = 3'd6;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        COMPARE    = ST_COMPARE,
        LEARN      = ST_LEARN,
        LEARN_CLR  = ST_LEARN_CLR,
        UPDATE     = ST_UPDATE,
        UPDATE_CLR = ST_UPDATE_CLR,
        DIV        = ST_DIV
    } state_t;

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Debounces one active-low push-button and emits a single-cycle pulse on
// each accepted press (debounced 1->0 transition).
// Ports:
//   CLOCK_50  system clock
//   rst       synchronous active-high reset (debounced level resets high)
//   key       raw asynchronous button, active-low
//   press     one-cycle pulse per accepted press
module key_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic rst,
    input  logic key,
    output logic press
);

    localparam int STAB_W = $clog2(DEB_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEB_CYCLES - 1);

    logic              sync_a;
    logic              sync_b;
    logic              level;
    logic [STAB_W-1:0] stable_cnt;

    // Two-flop synchroniser feeding a stability counter. The counter only
    // advances while the synchronised sample disagrees with the accepted
    // level; any agreeing sample restarts it, so the level flips only after
    // DEB_CYCLES consecutive differing samples.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            sync_a     <= 1'b1;
            sync_b     <= 1'b1;
            level      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            sync_a <= key;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                stable_cnt <= '0;
            end else if (stable_cnt == STAB_LAST) begin
                level      <= sync_b;
                stable_cnt <= '0;
                press      <= ~sync_b;
            end else begin
                stable_cnt <= stable_cnt + STAB_W'(1);
            end
        end
    end

endmodule

// File: rtl/predictor_sequencer.sv
// predictor_sequencer
// Central controller for the perceptron branch-predictor datapath. Turns
// debounced key presses into symbols, then walks compare, learn, neuron
// update and statistics phases, finishing with an iterative restoring
// divider that produces the saturated hit ratio for the LEDs.
// Ports:
//   CLOCK_50    system clock
//   rst         synchronous active-high reset
//   key0/key1   raw active-low buttons (+1 / -1 symbol)
//   y           signed Q4.5 prediction
//   abs_w       signed Q4.5 weight norm
//   xin         current symbol (01 = +1, 11 = -1)
//   learn_clk   one-cycle learn strobe
//   update_clk  one-cycle neuron shift strobe
//   busy        high while a sequence is in progress
//   led         saturated floor(hits*256/total)
module predictor_sequencer
    import predictor_pkg::*;
#(
    parameter int                     DEB_CYCLES = 500000,
    parameter logic signed [Q_W-1:0]  GAMMA      = GAMMA_DEFAULT,
    parameter int                     CNT_W      = 10
) (
    input  logic                  CLOCK_50,
    input  logic                  rst,
    input  logic                  key0,
    input  logic                  key1,
    input  logic signed [Q_W-1:0] y,
    input  logic signed [Q_W-1:0] abs_w,
    output logic [1:0]            xin,
    output logic                  learn_clk,
    output logic                  update_clk,
    output logic                  busy,
    output logic [LED_W-1:0]      led
);

    localparam int QUO_W     = CNT_W + LED_W;
    localparam int REM_W     = CNT_W + 1;
    localparam int DIV_CNT_W = $clog2(QUO_W);
    localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(QUO_W - 1);
    localparam logic [CNT_W-1:0]     WRAP_AT  = CNT_W'((1 << CNT_W) - 2);

    logic press0;
    logic press1;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb0 (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .key      (key0),
        .press    (press0)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb1 (
        .CLOCK_50 (CLOCK_50),
        .rst      (rst),
        .key      (key1),
        .press    (press1)
    );

    state_t               state;
    logic                 mispredict;
    logic                 margin_ok;
    logic [CNT_W-1:0]     hits;
    logic [CNT_W-1:0]     total;
    logic [REM_W-1:0]     rem;
    logic [QUO_W-1:0]     quo;
    logic [DIV_CNT_W-1:0] div_cnt;

    // Compare-phase terms: the magnitude of y is moved into Q8.10 so it
    // lines up with the GAMMA*abs_w product; a negative norm never passes.
    logic signed [Q_W-1:0]    y_mag;
    logic signed [PROD_W-1:0] y_scaled;
    logic signed [PROD_W-1:0] margin_lim;
    logic                     mispredict_comb;
    logic                     margin_comb;

    assign y_mag           = y[Q_W-1] ? -y : y;
    assign y_scaled        = $signed({{(PROD_W-Q_W){y_mag[Q_W-1]}}, y_mag}) <<< Q_FRAC;
    assign margin_lim      = GAMMA * abs_w;
    assign mispredict_comb = xin[1] ^ y[Q_W-1];
    assign margin_comb     = !abs_w[Q_W-1] && (y_scaled <= margin_lim);

    // Statistics update: halve both counters just before total would hit
    // the all-ones value, which keeps the ratio and prevents overflow.
    logic             wrap;
    logic [CNT_W-1:0] hits_base;
    logic [CNT_W-1:0] total_base;

    assign wrap       = (total == WRAP_AT);
    assign hits_base  = wrap ? (hits >> 1)  : hits;
    assign total_base = wrap ? (total >> 1) : total;

    // One restoring-division step: quo holds the not-yet-consumed dividend
    // bits at the top and collects quotient bits at the bottom.
    logic [REM_W-1:0] rem_shift;
    logic             rem_ge;
    logic [REM_W-1:0] rem_next;
    logic [QUO_W-1:0] quo_next;
    logic [LED_W-1:0] led_next;

    always_comb begin
        rem_shift = {rem[REM_W-2:0], quo[QUO_W-1]};
        rem_ge    = (rem_shift >= {1'b0, total});
        rem_next  = rem_ge ? (rem_shift - {1'b0, total}) : rem_shift;
        quo_next  = {quo[QUO_W-2:0], rem_ge};
        led_next  = quo_next[LED_W-1:0];
        if (total == '0) begin
            led_next = '0;
        end else if (|quo_next[QUO_W-1:LED_W]) begin
            led_next = '1;
        end
    end

    // Sequencer. Each state's outputs are registered on the edge that
    // leaves it, giving learn_clk two cycles and update_clk four cycles
    // after the accepted event, and led/busy settling after 23 cycles.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state      <= IDLE;
            xin        <= SYM_POS;
            learn_clk  <= 1'b0;
            update_clk <= 1'b0;
            busy       <= 1'b0;
            led        <= '0;
            hits       <= '0;
            total      <= '0;
            mispredict <= 1'b0;
            margin_ok  <= 1'b0;
            rem        <= '0;
            quo        <= '0;
            div_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (press0 || press1) begin
                        xin   <= press0 ? SYM_POS : SYM_NEG;
                        busy  <= 1'b1;
                        state <= COMPARE;
                    end
                end
                COMPARE: begin
                    mispredict <= mispredict_comb;
                    margin_ok  <= margin_comb;
                    state      <= LEARN;
                end
                LEARN: begin
                    learn_clk <= mispredict | margin_ok;
                    hits      <= hits_base + CNT_W'(!mispredict);
                    total     <= total_base + CNT_W'(1);
                    state     <= LEARN_CLR;
                end
                LEARN_CLR: begin
                    learn_clk <= 1'b0;
                    state     <= UPDATE;
                end
                UPDATE: begin
                    update_clk <= 1'b1;
                    state      <= UPDATE_CLR;
                end
                UPDATE_CLR: begin
                    update_clk <= 1'b0;
                    quo        <= {hits, {LED_W{1'b0}}};
                    rem        <= '0;
                    div_cnt    <= '0;
                    state      <= DIV;
                end
                DIV: begin
                    rem     <= rem_next;
                    quo     <= quo_next;
                    div_cnt <= div_cnt + DIV_CNT_W'(1);
                    if (div_cnt == DIV_LAST) begin
                        led   <= led_next;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_predictor_sequencer.sv
// tb_predictor_sequencer
// Scoreboard bench: each stimulus pushes its expected sequence outcome,
// and an independent monitor pops and compares whenever a sequence ends.
module tb_predictor_sequencer;

    localparam int DEB = 8;

    logic              CLOCK_50 = 1'b0;
    logic              rst      = 1'b1;
    logic              key0     = 1'b1;
    logic              key1     = 1'b1;
    logic signed [9:0] y        = '0;
    logic signed [9:0] abs_w    = '0;
    logic [1:0]        xin;
    logic              learn_clk;
    logic              update_clk;
    logic              busy;
    logic [7:0]        led;

    predictor_sequencer #(
        .DEB_CYCLES (DEB),
        .GAMMA      (10'sd45),
        .CNT_W      (10)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .rst        (rst),
        .key0       (key0),
        .key1       (key1),
        .y          (y),
        .abs_w      (abs_w),
        .xin        (xin),
        .learn_clk  (learn_clk),
        .update_clk (update_clk),
        .busy       (busy),
        .led        (led)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic [1:0] xin;
        int         learn_cnt;
        int         learn_off;
        int         dur;
        int         led;
    } exp_t;

    exp_t exp_q[$];
    int   checks      = 0;
    int   passed      = 0;
    int   pushed      = 0;
    int   seen        = 0;
    int   model_hits  = 0;
    int   model_total = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference model of one sequence, pushed before the key is driven
    task automatic pushExpect(input int which, input logic signed [9:0] y_in,
                              input logic signed [9:0] w_in);
        exp_t e;
        bit   mis;
        bit   marg;
        int   ay;
        int   w;
        y     = y_in;
        abs_w = w_in;
        e.xin = (which == 0) ? 2'b01 : 2'b11;
        mis   = e.xin[1] ^ y_in[9];
        ay    = (y_in < 0) ? -int'(y_in) : int'(y_in);
        w     = int'(w_in);
        marg  = (w >= 0) && (ay * 32 <= 45 * w);
        e.learn_cnt = (mis || marg) ? 1 : 0;
        e.learn_off = (mis || marg) ? 2 : -1;
        if (model_total + 1 == 1023) begin
            model_hits  = model_hits / 2;
            model_total = model_total / 2;
        end
        model_hits  += mis ? 0 : 1;
        model_total += 1;
        e.led = (model_hits * 256) / model_total;
        if (e.led > 255) e.led = 255;
        e.dur = 23;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 100) checkOutput("idle_timeout", 1, 0);
    endtask

    task automatic driveKey(input int which, input logic val);
        if (which == 0) key0 = val;
        else key1 = val;
    endtask

    task automatic applyStimulus(input int which, input logic signed [9:0] y_in,
                                 input logic signed [9:0] w_in);
        pushExpect(which, y_in, w_in);
        @(negedge CLOCK_50);
        driveKey(which, 1'b0);
        repeat (DEB + 4) @(negedge CLOCK_50);
        driveKey(which, 1'b1);
        repeat (DEB + 4) @(negedge CLOCK_50);
        waitIdle();
    endtask

    task automatic resetDut();
        @(negedge CLOCK_50);
        rst = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        checkOutput("reset_xin", xin, 1);
        checkOutput("reset_learn_clk", learn_clk, 0);
        checkOutput("reset_update_clk", update_clk, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_led", led, 0);
        rst = 1'b0;
        model_hits  = 0;
        model_total = 0;
    endtask

    // Monitor: follows each busy window, then pops and compares
    initial begin : monitor_proc
        int         cyc;
        bit         active;
        int         learn_cnt;
        int         learn_off;
        int         upd_cnt;
        int         upd_off;
        bit         overlap;
        logic [1:0] xin_seen;
        exp_t       e;
        active = 1'b0;
        cyc = 0; learn_cnt = 0; learn_off = -1; upd_cnt = 0; upd_off = -1;
        overlap = 1'b0; xin_seen = 2'b00;
        forever begin
            @(negedge CLOCK_50);
            if (!active && busy) begin
                active    = 1'b1;
                cyc       = 0;
                learn_cnt = 0;
                learn_off = -1;
                upd_cnt   = 0;
                upd_off   = -1;
                overlap   = 1'b0;
                xin_seen  = xin;
            end else if (active) begin
                cyc++;
            end
            if (active) begin
                if (learn_clk) begin
                    if (learn_off < 0) learn_off = cyc;
                    learn_cnt++;
                end
                if (update_clk) begin
                    if (upd_off < 0) upd_off = cyc;
                    upd_cnt++;
                end
                if (learn_clk && update_clk) overlap = 1'b1;
                if (!busy) begin
                    active = 1'b0;
                    seen++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_sequence", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("xin", xin_seen, e.xin);
                        checkOutput("busy_cycles", cyc, e.dur);
                        checkOutput("learn_pulses", learn_cnt, e.learn_cnt);
                        checkOutput("learn_offset", learn_off, e.learn_off);
                        checkOutput("update_pulses", upd_cnt, 1);
                        checkOutput("update_offset", upd_off, 4);
                        checkOutput("strobe_overlap", overlap, 0);
                        checkOutput("led", led, e.led);
                    end
                end
            end
        end
    end

    // Overall time bound
    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus_proc
        int n;
        exp_t e;

        // Reset, clean key0 with no learn, saturated ratio
        resetDut();
        applyStimulus(0, 10'sd20, 10'sd4);

        // Mispredict learn after fresh reset
        resetDut();
        applyStimulus(1, 10'sd10, 10'sd4);

        // Margin-only learn, negative y correct, negative norm
        applyStimulus(0, 10'sd1, 10'sd4);
        applyStimulus(1, -10'sd20, 10'sd4);
        applyStimulus(0, 10'sd1, -10'sd4);

        // Bounce shorter than the debounce window, then a clean hold
        pushExpect(0, 10'sd20, 10'sd4);
        @(negedge CLOCK_50);
        for (int i = 0; i < 20; i++) begin
            key0 = ~key0;
            repeat (3) @(negedge CLOCK_50);
        end
        key0 = 1'b0;
        repeat (DEB + 4) @(negedge CLOCK_50);
        key0 = 1'b1;
        repeat (DEB + 4) @(negedge CLOCK_50);
        waitIdle();
        repeat (5) @(negedge CLOCK_50);
        checkOutput("bounce_sequences", seen, pushed);

        // A key1 press landing in DIV is dropped
        pushExpect(0, 10'sd20, 10'sd4);
        @(negedge CLOCK_50);
        key0 = 1'b0;
        n = 0;
        while (!busy && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 100) checkOutput("busy_timeout", 1, 0);
        repeat (5) @(negedge CLOCK_50);
        key0 = 1'b1;
        key1 = 1'b0;
        repeat (DEB + 4) @(negedge CLOCK_50);
        key1 = 1'b1;
        repeat (DEB + 4) @(negedge CLOCK_50);
        waitIdle();
        repeat (30) @(negedge CLOCK_50);
        checkOutput("dropped_event_sequences", seen, pushed);

        // Reset while update_clk is high
        y     = 10'sd20;
        abs_w = 10'sd4;
        e.xin = 2'b01; e.learn_cnt = 0; e.learn_off = -1; e.dur = 5; e.led = 0;
        exp_q.push_back(e);
        pushed++;
        @(negedge CLOCK_50);
        key0 = 1'b0;
        n = 0;
        while (!update_clk && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 100) checkOutput("update_timeout", 1, 0);
        rst  = 1'b1;
        key0 = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("midreset_update_clk", update_clk, 0);
        checkOutput("midreset_learn_clk", learn_clk, 0);
        checkOutput("midreset_busy", busy, 0);
        checkOutput("midreset_led", led, 0);
        rst = 1'b0;
        model_hits  = 0;
        model_total = 0;
        repeat (DEB + 4) @(negedge CLOCK_50);
        applyStimulus(1, 10'sd10, 10'sd4);

        // Preload 1022 events (511 correct), then cross the wrap point
        resetDut();
        for (int k = 0; k < 1022; k++) begin
            applyStimulus(k % 2, 10'sd20, 10'sd4);
        end
        applyStimulus(0, 10'sd20, 10'sd4);
        applyStimulus(1, 10'sd20, 10'sd4);
        applyStimulus(0, 10'sd1, 10'sd4);

        repeat (40) @(negedge CLOCK_50);
        checkOutput("sequences_seen", seen, pushed);
        checkOutput("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/predictor_sequencer.md
Name: predictor_sequencer

Overview:
- Central controller for the perceptron branch-predictor datapath (neurons, weight_module, norm, prediction).
- Turns debounced key presses into input symbols, then sequences compare, learn, neuron-update and statistics phases.
- Drives the single-cycle learn and update strobes, keeps hit/total statistics and computes the saturated 8-bit accuracy ratio for the LEDs with an iterative divider, so the datapath needs no combinational divider.

Parameters:
- DEB_CYCLES, 500000, key must be stable this many clocks before an edge is accepted (10 ms at 50 MHz).
- GAMMA, 10'sd45, learn margin, signed Q4.5.
- CNT_W, 10, width of hit/total counters.

Ports:
- CLOCK_50  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- key0  input  1  raw push-button, active-low; press = symbol +1.
- key1  input  1  raw push-button, active-low; press = symbol -1.
- y  input  10  signed Q4.5 prediction; only the sign and magnitude are used.
- abs_w  input  10  signed Q4.5 weight norm.
- xin  output  2  signed current symbol, 2'b01 (+1) or 2'b11 (-1).
- learn_clk  output  1  one-cycle learn strobe to weight_module.
- update_clk  output  1  one-cycle shift strobe to neurons.
- busy  output  1  high whenever the FSM is not in IDLE.
- led  output  8  saturated accuracy ratio.

Behaviour:
- Reset values: xin=2'b01, learn_clk=0, update_clk=0, busy=0, led=0, hits=0, total=0, FSM=IDLE, debouncers stable high.
- Debounce:
  - Each key is passed through a 2-flop synchroniser, then a per-key stability counter.
  - The debounced level changes only after DEB_CYCLES equal consecutive samples.
  - A press event is a debounced 1->0 transition.
- Event acceptance:
  - Events are accepted only in IDLE.
  - Events occurring while busy are dropped; there is no queue.
  - If both keys produce an event in the same cycle, key0 wins (xin=01).
- FSM states, one cycle each unless stated:
  - IDLE: on an accepted event, latch xin and go to COMPARE.
  - COMPARE:
    - Register mispredict = xin[1] ^ y[9].
    - Register margin_ok = (|y| sign-extended to 20 bits, shifted left 5) <= GAMMA*abs_w (20-bit signed Q8.10 product).
    - If abs_w is negative, margin_ok = 0.
  - LEARN:
    - learn_clk = mispredict | margin_ok.
    - hits += !mispredict; total += 1.
  - LEARN_CLR: learn_clk=0.
  - UPDATE: update_clk=1.
  - UPDATE_CLR: update_clk=0.
  - DIV:
    - Restoring division of {hits,8'b0} by total, one quotient bit per cycle, 18 cycles.
    - led = (quotient>255) ? 255 : quotient[7:0]; led is updated only on the final cycle.
    - Then return to IDLE.
- Latency: event in IDLE to learn_clk high = 2 cycles; to update_clk high = 4 cycles; to led valid and busy low = 23 cycles.
- Counter wrap: when total would reach 2^CNT_W-1, both hits and total are halved (logical shift right 1) in the same cycle before the increment. The ratio is preserved and no overflow occurs.
- Division guard: total=0 is impossible in DIV (total is at least 1); the divider still forces led=0 if the divisor is 0.
- Reset mid-sequence: learn_clk and update_clk drop in the same cycle rst is sampled; the FSM returns to IDLE; counters and led are cleared.
- Strobe exclusivity: learn_clk and update_clk are never high in the same cycle.

Decomposition:
- Shared package (predictor_pkg):
  - FSM state encoding localparams.
  - Q4.5 format widths and fraction bits.
  - Symbol constants SYM_POS=2'b01 and SYM_NEG=2'b11.
  - Default GAMMA.
- Sub-module key_debounce (one instance per key): synchroniser, stability counter, press-pulse output.
- The divider stays inline in the sequencer.

Test Plan:
- Reset, then a single clean key0 press with y=+20 and abs_w=4:
  - No mispredict; margin 640 <= 180 false, so learn_clk stays 0.
  - update_clk pulses exactly once.
  - hits=1, total=1, led=255 (256 saturated).
- key1 press with y=+10 and abs_w=4: mispredict, so learn_clk pulses 1 cycle; hits=0, total=1, led=0.
- Margin-only learn: key0 press with y=+1 and abs_w=4. Margin 32 <= 180, so learn_clk pulses although the prediction is correct; hits increments.
- Bounce rejection:
  - key0 toggling every 1000 cycles for 50k cycles, then stable low, gives exactly one event.
  - A second key press during DIV is dropped; total increments only once.
- Saturation: preload via 1022 events, 511 correct. The next event halves the counters to hits=255, total=511 before incrementing. Check led=floor(hits*256/total) against a reference model.
- Mid-sequence reset: assert rst the cycle update_clk is high. update_clk=0 next cycle, busy=0, led=0, and a following key press runs a full clean sequence.
